// File: rtl/pe_pkg.sv
// Shared types and constants for the PE result path (writer FSM, counts, address stepping).
package pe_pkg;
  localparam int CNT_W      = 16;
  localparam int STRIDE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } wr_state_t;
endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO decoupling PE pops from memory write acceptance.
module result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("result_fifo: DEPTH must be a power of two >= 2");
  end

  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [AW:0] wp, rp;
  logic [DEPTH-1:0][DATA_W-1:0] mem;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pe_result_writer.sv
// Drains PE results through a small buffer into memory at base + n*STRIDE; pulses done after count writes.
module pe_result_writer
  import pe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int STRIDE = STRIDE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] pe_data,
  input  logic              pe_empty,
  output logic              pe_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count
);
  wr_state_t         state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q, pop_cnt;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              accept, last_wr;

  // Pops stop at count so words of the next job stay queued in the PE.
  assign pe_rd   = (state == RUN) && !pe_empty && !fifo_full && (pop_cnt < cnt_q);
  assign mem_we  = (state == RUN) && !fifo_empty;
  assign accept  = mem_we && mem_ready;
  assign last_wr = accept && (wr_count == cnt_q - CNT_W'(1));

  // Gated so a reset (which leaves buffer storage untouched) shows all-zero write outputs.
  assign mem_wdata = mem_we ? fifo_head : '0;
  assign mem_addr  = mem_we ? addr_q : '0;

  result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pe_rd),
    .din   (pe_data),
    .pop   (accept),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      pop_cnt  <= '0;
      wr_count <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr_q   <= base_addr;
            cnt_q    <= count;
            pop_cnt  <= '0;
            wr_count <= '0;
            if (count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pe_rd) pop_cnt <= pop_cnt + CNT_W'(1);
          if (accept) begin
            wr_count <= wr_count + CNT_W'(1);
            addr_q   <= addr_q + ADDR_W'(STRIDE);
          end
          if (last_wr) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
